// File: rtl/ntt_output_reorder_buffer.sv
// ntt_output_reorder_buffer: ping-pong capture of bit-reversed NTT frames, natural-order streaming with optional N^-1 scaling
module ntt_output_reorder_buffer #(
  parameter int W         = 32,
  parameter int N         = 8,
  parameter int MODULUS_Q = 241,
  parameter int N_INV     = 211
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0][W-1:0]       frame_in,
  input  logic                      frame_valid_in,
  input  logic                      frame_mode_in,
  output logic [W-1:0]              out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N)-1:0]      out_index,
  output logic                      out_last,
  output logic                      out_mode,
  output logic                      overflow,
  output logic [1:0]                frames_pending
);
  localparam int LG = $clog2(N);
  localparam int P  = 2 * W;

  function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] x);
    logic [LG-1:0] r;
    for (int b = 0; b < LG; b++) r[b] = x[LG-1-b];
    return r;
  endfunction

  logic [N-1:0][W-1:0] mem_q [2];
  logic [N-1:0][W-1:0] mem_d [2];
  logic [1:0]          full_q, full_d, mode_q, mode_d;
  logic                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ob_q, ob_d;
  logic [LG-1:0]       k_q, k_d, out_index_q, out_index_d;
  logic [W-1:0]        out_data_q, out_data_d, word;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                out_mode_q, out_mode_d, overflow_q, overflow_d;
  logic                hs, free, cap, load;
  logic [P-1:0]        prod;

  // ob_q remembers which bank the registered word came from, so the bank is
  // released on its last handshake even though rd_ptr has already moved on
  always_comb begin
    hs          = out_valid_q && out_ready;
    free        = !full_q[wr_ptr_q] || (hs && out_last_q && ob_q == wr_ptr_q);
    cap         = frame_valid_in && free;
    load        = (!out_valid_q || hs) && full_q[rd_ptr_q];
    word        = mem_q[rd_ptr_q][bitrev(k_q)];
    prod        = P'(word) * P'(N_INV);
    mem_d       = mem_q;
    mode_d      = mode_q;
    full_d      = full_q;
    if (hs && out_last_q) full_d[ob_q] = 1'b0;
    if (cap) begin
      mem_d[wr_ptr_q]  = frame_in;
      mode_d[wr_ptr_q] = frame_mode_in;
      full_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d    = wr_ptr_q ^ cap;
    rd_ptr_d    = rd_ptr_q ^ (load && k_q == LG'(N-1));
    k_d         = load ? k_q + 1'b1 : k_q;
    ob_d        = load ? rd_ptr_q : ob_q;
    out_valid_d = load || (out_valid_q && !hs);
    out_data_d  = load ? (mode_q[rd_ptr_q] ? W'(prod % P'(MODULUS_Q)) : word) : out_data_q;
    out_index_d = load ? k_q : out_index_q;
    out_last_d  = load ? (k_q == LG'(N-1)) : out_last_q;
    out_mode_d  = load ? mode_q[rd_ptr_q] : out_mode_q;
    overflow_d  = frame_valid_in && !free;
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q      <= '0;
      mode_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      ob_q        <= 1'b0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      out_mode_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      full_q      <= full_d;
      mode_q      <= mode_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ob_q        <= ob_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      out_mode_q  <= out_mode_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_index      = out_index_q;
  assign out_last       = out_last_q;
  assign out_mode       = out_mode_q;
  assign overflow       = overflow_q;
  assign frames_pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};
endmodule
